// File: rtl/hex_message_scroller_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : hex_message_scroller_if
// Purpose : Control/write bus and display outputs of the HEX message scroller.
//           The master drives mode, step and write requests. The slave returns
//           per-display codes, the current offset and the step tick.
// Revision: 1.0  initial release
// ============================================================================
interface hex_message_scroller_if #(
  parameter int NUM_DISP = 6,
  parameter int MSG_LEN  = 8,
  parameter int ADDR_W   = $clog2(MSG_LEN),
  parameter int OFF_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
);
  logic                    run;
  logic                    dir;
  logic                    step;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [2:0]              wr_data;
  logic [3*NUM_DISP-1:0]   disp_code;
  logic [OFF_W-1:0]        offset;
  logic                    tick;

  modport master (
    output run, dir, step, wr_en, wr_addr, wr_data,
    input  disp_code, offset, tick
  );

  modport slave (
    input  run, dir, step, wr_en, wr_addr, wr_data,
    output disp_code, offset, tick
  );
endinterface
`default_nettype wire

// File: rtl/hex_message_scroller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : hex_message_scroller
// Purpose : Holds a MSG_LEN-slot message of 3-bit character codes and rotates
//           it across NUM_DISP seven-segment displays. It scrolls either at a
//           TICK_DIV-cycle rate (RUN) or on single step pulses (HOLD).
// Revision: 1.0  initial release
// ============================================================================
module hex_message_scroller #(
  parameter int NUM_DISP = 6,
  parameter int MSG_LEN  = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int ADDR_W   = $clog2(MSG_LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_message_scroller_if.slave   bus
);

  localparam int OFF_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [OFF_W-1:0] LAST_SLOT = OFF_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       div_cnt;
  logic [CNT_W-1:0]       div_cnt_nx;
  logic [OFF_W-1:0]       offset;
  logic [OFF_W-1:0]       offset_nx;
  logic [2:0]             msg    [MSG_LEN];
  logic [2:0]             msg_nx [MSG_LEN];
  logic [3*NUM_DISP-1:0]  disp_code;
  logic [3*NUM_DISP-1:0]  disp_nx;
  logic                   tick;
  logic                   step_now;
  logic                   wr_hit;
  logic [OFF_W-1:0]       wr_slot;

  // Power-on message: "dE102" followed by blanks.
  function automatic logic [2:0] boot_code(input int slot);
    return (slot < 5) ? 3'(slot) : 3'b111;
  endfunction

  // Mode FSM plus the rate divider; decides whether a step is applied this cycle.
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    step_now   = 1'b0;
    case (state)
      HOLD: begin
        step_now = bus.step;
        if (bus.run) begin
          state_nx   = RUN;
          div_cnt_nx = '0;
        end
      end
      RUN: begin
        if (div_cnt == LAST_CNT) begin
          div_cnt_nx = '0;
          step_now   = 1'b1;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
        if (!bus.run) begin
          state_nx = HOLD;
        end
      end
      default: state_nx = HOLD;
    endcase
  end

  // Next offset, wrapping at both ends of the message.
  always_comb begin
    offset_nx = offset;
    if (step_now) begin
      if (bus.dir) begin
        offset_nx = (offset == '0) ? LAST_SLOT : offset - 1'b1;
      end else begin
        offset_nx = (offset == LAST_SLOT) ? '0 : offset + 1'b1;
      end
    end
  end

  // Message contents after this cycle's write; out-of-range addresses are dropped.
  always_comb begin
    wr_hit  = bus.wr_en && (32'(bus.wr_addr) < 32'(MSG_LEN));
    wr_slot = OFF_W'(bus.wr_addr);
    msg_nx  = msg;
    if (wr_hit) begin
      msg_nx[wr_slot] = bus.wr_data;
    end
  end

  // Next display frame built from the new offset and new contents together,
  // so a simultaneous write and step never shows a stale frame.
  always_comb begin
    disp_nx = '0;
    for (int i = 0; i < NUM_DISP; i++) begin
      disp_nx[3*i +: 3] = msg_nx[OFF_W'((int'(offset_nx) + i) % MSG_LEN)];
    end
  end

  // State, counter, message store and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      div_cnt <= '0;
      offset  <= '0;
      tick    <= 1'b0;
      for (int s = 0; s < MSG_LEN; s++) begin
        msg[s] <= boot_code(s);
      end
      for (int i = 0; i < NUM_DISP; i++) begin
        disp_code[3*i +: 3] <= boot_code(i);
      end
    end else begin
      state     <= state_nx;
      div_cnt   <= div_cnt_nx;
      offset    <= offset_nx;
      tick      <= step_now;
      msg       <= msg_nx;
      disp_code <= disp_nx;
    end
  end

  assign bus.disp_code = disp_code;
  assign bus.offset    = offset;
  assign bus.tick      = tick;

endmodule
`default_nettype wire

// File: tb/tb_hex_message_scroller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_hex_message_scroller
// Purpose : Scoreboard bench for hex_message_scroller. A message/offset model
//           predicts every output frame. A negedge monitor compares the frames.
// Revision: 1.0  initial release
// ============================================================================
module tb_hex_message_scroller;

  localparam int ND = 6;
  localparam int ML = 8;
  localparam int TD = 4;
  localparam int AW = 4;
  localparam logic [3*ND-1:0] RESET_DISP = 18'b111_100_011_010_001_000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hex_message_scroller_if #(.NUM_DISP(ND), .MSG_LEN(ML), .ADDR_W(AW)) bus ();

  hex_message_scroller #(
    .NUM_DISP (ND),
    .MSG_LEN  (ML),
    .TICK_DIV (TD),
    .ADDR_W   (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3*ND-1:0] disp;
    logic [2:0]      off;
    logic            tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   tick_seen = 0;

  // Reference model: message as an int array, offset as an int, mode flag.
  int m_msg [ML];
  int m_off;
  bit m_running;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < ML; s++) m_msg[s] = (s < 5) ? s : 7;
    m_off     = 0;
    m_running = 1'b0;
    m_cnt     = 0;
  endtask

  // One rising edge of the reference model, then push the predicted frame.
  task automatic model_edge();
    exp_t e;
    bit   do_step;
    do_step = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_running) begin
        do_step = (m_cnt == TD - 1);
        m_cnt   = do_step ? 0 : m_cnt + 1;
      end else begin
        do_step = bus.step;
        if (bus.run) m_cnt = 0;
      end
      m_running = bus.run;
      if (bus.wr_en && int'(bus.wr_addr) < ML) m_msg[int'(bus.wr_addr)] = int'(bus.wr_data);
      if (do_step) m_off = bus.dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
    end
    e.tick = do_step;
    e.off  = 3'(m_off);
    e.disp = '0;
    for (int i = 0; i < ND; i++) e.disp[3*i +: 3] = 3'(m_msg[(m_off + i) % ML]);
    sb.push_back(e);
  endtask

  // Inputs are set by the caller before this; they change again 2 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.step    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
  endtask

  // Monitor: every cycle produces a frame; compare it against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("disp_code", 32'(bus.disp_code), 32'(e.disp));
      check("offset",    32'(bus.offset),    32'(e.off));
      check("tick",      32'(bus.tick),      32'(e.tick));
      if (bus.tick) tick_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks_before;
    model_reset();
    bus.run = 1'b0;
    bus.dir = 1'b0;
    idle_inputs();

    // Reset held for a few edges, then released away from the clock edge.
    repeat (3) cycle();
    rst_n = 1'b1;
    settle();
    check("reset_disp",   32'(bus.disp_code), 32'(RESET_DISP));
    check("reset_offset", 32'(bus.offset),    32'd0);

    // Hold with no step: frame constant, no ticks.
    repeat (20) cycle();
    settle();
    check("hold_no_tick", 32'(tick_seen), 32'd0);

    // Auto-scroll left through a full rotation.
    bus.run = 1'b1;
    repeat (33) cycle();
    bus.run = 1'b0;
    cycle();
    settle();
    check("run_tick_count", 32'(tick_seen), 32'd8);
    check("rotation_disp",  32'(bus.disp_code), 32'(RESET_DISP));

    // Single right step from offset 0 wraps to the last slot.
    ticks_before = tick_seen;
    bus.dir  = 1'b1;
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    cycle();
    settle();
    check("step_right_off",  32'(bus.offset), 32'd7);
    check("step_right_d0",   32'(bus.disp_code[2:0]), 32'd7);
    check("step_right_d1",   32'(bus.disp_code[5:3]), 32'd0);
    check("step_right_tick", 32'(tick_seen - ticks_before), 32'd1);

    // Step back left to offset 0.
    bus.dir  = 1'b0;
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;

    // In-range write, then an out-of-range one.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 3'b000;
    cycle();
    bus.wr_addr = 4'd9; bus.wr_data = 3'b101;
    cycle();
    idle_inputs();
    cycle();
    settle();
    check("write_disp2", 32'(bus.disp_code[8:6]), 32'd0);

    // Write slot 1 on the same edge as a left step.
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 3'b100;
    bus.step  = 1'b1;
    cycle();
    idle_inputs();
    settle();
    check("wr_step_off",   32'(bus.offset), 32'd1);
    check("wr_step_disp0", 32'(bus.disp_code[2:0]), 32'd4);

    // Randomized mix of mode changes, direction, steps and writes.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 9) == 0)  bus.dir = ~bus.dir;
      bus.step    = ($urandom_range(0, 3) == 0);
      bus.wr_en   = ($urandom_range(0, 2) == 0);
      bus.wr_addr = 4'($urandom_range(0, 15));
      bus.wr_data = 3'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();

    // Asynchronous reset between ticks while running.
    bus.run = 1'b1;
    bus.dir = 1'b0;
    repeat (6) cycle();
    settle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_disp", 32'(bus.disp_code), 32'(RESET_DISP));
    check("async_rst_off",  32'(bus.offset),    32'd0);
    check("async_rst_tick", 32'(bus.tick),      32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (10) cycle();

    bus.run = 1'b0;
    repeat (3) cycle();
    settle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
